nearest_center_select: RTL and testbench

- Streaming consumer of point-to-center Manhattan distances for the kd-tree k-means datapath.
- Latches one query point, accepts a stream of candidate centers over a valid/ready handshake, and computes each distance in a 2-stage pipeline.
- Tracks the running minimum and reports the best index, distance and center once the stream ends.
- Sits downstream of tree traversal and feeds the cluster-assignment and accumulation logic.

---
 rtl/nearest_center_select.sv | 183 ++++++++++++++++++
 tb/tb_nearest_center_select.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nearest_center_select.sv
// Nearest-center selector: streams candidate centers against a latched
// query point and reports the one with the smallest Manhattan distance.
module nearest_center_select #(
  parameter int dim = 3,
  parameter int data_range = 255,
  parameter int num_centers = 8,
  localparam int dim_size = $clog2(data_range),
  localparam int idx_size = $clog2(num_centers),
  localparam int dist_size = $clog2(data_range * dim),
  localparam int center_size = dim * dim_size
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [center_size-1:0] point,
  input  logic                   cand_valid,
  output logic                   cand_ready,
  input  logic [center_size-1:0] cand_center,
  input  logic                   cand_last,
  output logic                   busy,
  output logic                   done,
  output logic [idx_size-1:0]    best_idx,
  output logic [dist_size-1:0]   best_dist,
  output logic [center_size-1:0] best_center
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [center_size-1:0] point_q, point_d;
  logic [idx_size-1:0]    count_q, count_d;

  logic                   s1_valid_q, s1_valid_d;
  logic [center_size-1:0] s1_delta_q, s1_delta_d;
  logic [idx_size-1:0]    s1_idx_q, s1_idx_d;
  logic [center_size-1:0] s1_center_q, s1_center_d;
  logic                   s2_valid_q, s2_valid_d;

  logic [dist_size-1:0]   run_dist_q, run_dist_d;
  logic [idx_size-1:0]    run_idx_q, run_idx_d;
  logic [center_size-1:0] run_center_q, run_center_d;

  logic [dist_size-1:0]   res_dist_q, res_dist_d;
  logic [idx_size-1:0]    res_idx_q, res_idx_d;
  logic [center_size-1:0] res_center_q, res_center_d;

  logic                   xfer;
  logic [center_size-1:0] delta;
  logic [dist_size-1:0]   sum;

  assign cand_ready  = (state_q == S_ACCUM);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign best_idx    = res_idx_q;
  assign best_dist   = res_dist_q;
  assign best_center = res_center_q;

  // Per-axis |p - c| by compare-and-subtract, exact over the full range.
  always_comb begin
    delta = '0;
    for (int i = 0; i < dim; i++) begin
      if (point_q[i*dim_size +: dim_size] >= cand_center[i*dim_size +: dim_size])
        delta[i*dim_size +: dim_size] = point_q[i*dim_size +: dim_size]
                                      - cand_center[i*dim_size +: dim_size];
      else
        delta[i*dim_size +: dim_size] = cand_center[i*dim_size +: dim_size]
                                      - point_q[i*dim_size +: dim_size];
    end
  end

  // Zero-extended sum of the registered deltas; wide enough to never wrap.
  always_comb begin
    sum = '0;
    for (int i = 0; i < dim; i++)
      sum = sum + dist_size'(s1_delta_q[i*dim_size +: dim_size]);
  end

  // Next-state: FSM, stage 1 capture, stage 2 running-min, result latch.
  always_comb begin
    state_d      = state_q;
    point_d      = point_q;
    count_d      = count_q;
    s1_valid_d   = 1'b0;
    s1_delta_d   = s1_delta_q;
    s1_idx_d     = s1_idx_q;
    s1_center_d  = s1_center_q;
    s2_valid_d   = s1_valid_q;
    run_dist_d   = run_dist_q;
    run_idx_d    = run_idx_q;
    run_center_d = run_center_q;
    res_dist_d   = res_dist_q;
    res_idx_d    = res_idx_q;
    res_center_d = res_center_q;
    xfer         = cand_valid && (state_q == S_ACCUM);

    if (xfer) begin
      s1_valid_d  = 1'b1;
      s1_delta_d  = delta;
      s1_idx_d    = count_q;
      s1_center_d = cand_center;
    end

    if (s1_valid_q && (sum < run_dist_q)) begin
      run_dist_d   = sum;
      run_idx_d    = s1_idx_q;
      run_center_d = s1_center_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ACCUM;
          point_d      = point;
          count_d      = '0;
          run_dist_d   = '1;
          res_dist_d   = '0;
          res_idx_d    = '0;
          res_center_d = '0;
        end
      end
      S_ACCUM: begin
        if (xfer) begin
          count_d = count_q + 1'b1;
          if (cand_last || (count_q == idx_size'(num_centers - 1)))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d      = S_DONE;
          res_dist_d   = run_dist_q;
          res_idx_d    = run_idx_q;
          res_center_d = run_center_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      point_q      <= '0;
      count_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_delta_q   <= '0;
      s1_idx_q     <= '0;
      s1_center_q  <= '0;
      s2_valid_q   <= 1'b0;
      run_dist_q   <= '1;
      run_idx_q    <= '0;
      run_center_q <= '0;
      res_dist_q   <= '0;
      res_idx_q    <= '0;
      res_center_q <= '0;
    end else begin
      state_q      <= state_d;
      point_q      <= point_d;
      count_q      <= count_d;
      s1_valid_q   <= s1_valid_d;
      s1_delta_q   <= s1_delta_d;
      s1_idx_q     <= s1_idx_d;
      s1_center_q  <= s1_center_d;
      s2_valid_q   <= s2_valid_d;
      run_dist_q   <= run_dist_d;
      run_idx_q    <= run_idx_d;
      run_center_q <= run_center_d;
      res_dist_q   <= res_dist_d;
      res_idx_q    <= res_idx_d;
      res_center_q <= res_center_d;
    end
  end

endmodule

// File: tb/tb_nearest_center_select.sv
// Bench for nearest_center_select: directed queries, a behavioural
// running-minimum model compared every cycle, plus literal expectations.
module tb_nearest_center_select;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] point = '0;
  logic        cand_valid = 1'b0;
  logic        cand_ready;
  logic [23:0] cand_center = '0;
  logic        cand_last = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  best_idx;
  logic [9:0]  best_dist;
  logic [23:0] best_center;

  always #5 clk = ~clk;

  nearest_center_select dut (
    .clk(clk), .rst(rst), .start(start), .point(point),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_center(cand_center), .cand_last(cand_last),
    .busy(busy), .done(done), .best_idx(best_idx),
    .best_dist(best_dist), .best_center(best_center)
  );

  int pass_cnt = 0;
  int chk_cnt = 0;
  int e = 0;
  int last_xfer = 0;

  bit          m_active = 0;
  bit          m_accepting = 0;
  logic [23:0] m_p = '0;
  int          m_n = 0;
  int          m_bd = 0;
  int          m_bi = 0;
  logic [23:0] m_bc = '0;
  int          m_done_edge = -1;
  logic [2:0]  r_i = '0;
  logic [9:0]  r_d = '0;
  logic [23:0] r_c = '0;

  function automatic logic [23:0] pk(int x, int y, int z);
    logic [7:0] a, b, c;
    a = 8'(x); b = 8'(y); c = 8'(z);
    return {c, b, a};
  endfunction

  function automatic int mdist(logic [23:0] p, logic [23:0] c);
    int s = 0;
    for (int i = 0; i < 3; i++) begin
      int a = int'(p[i*8 +: 8]);
      int b = int'(c[i*8 +: 8]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: query is open from an honoured start; the nearest
  // (strictly smaller, earliest on ties) of up to 8 accepted candidates is
  // published 3 edges after the final transfer, done lasts one cycle.
  always @(posedge clk) begin
    bit was_active;
    int d;
    e = e + 1;
    if (rst) begin
      m_active = 0; m_accepting = 0; m_done_edge = -1;
      r_i = '0; r_d = '0; r_c = '0;
    end else begin
      was_active = m_active;
      if (m_accepting && cand_valid) begin
        d = mdist(m_p, cand_center);
        if (d < m_bd) begin
          m_bd = d; m_bi = m_n; m_bc = cand_center;
        end
        m_n++;
        if (cand_last || m_n == 8) begin
          m_accepting = 0;
          m_done_edge = e + 3;
        end
      end
      if (e == m_done_edge) begin
        r_i = 3'(m_bi); r_d = 10'(m_bd); r_c = m_bc;
      end
      if (e == m_done_edge + 1) m_active = 0;
      if (!was_active && start) begin
        m_active = 1; m_accepting = 1; m_p = point; m_n = 0;
        m_bd = 1 << 30; r_i = '0; r_d = '0; r_c = '0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (e > 0)
      chk("cycle_outputs",
          {cand_ready, busy, done, best_idx, best_dist, best_center},
          {m_accepting, m_active, (e == m_done_edge), r_i, r_d, r_c});
  end

  task automatic do_start(logic [23:0] p);
    start = 1'b1; point = p;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [23:0] c, bit last, int stall);
    int n = 0;
    cand_valid = 1'b0;
    repeat (stall) @(negedge clk);
    cand_valid = 1'b1; cand_center = c; cand_last = last;
    while (!cand_ready && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    last_xfer = e;
  endtask

  task automatic idle();
    cand_valid = 1'b0; cand_last = 1'b0;
  endtask

  task automatic wait_done(string name, int ei, int ed, logic [23:0] ec);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk); n++;
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_latency"}, 64'(e - last_xfer), 64'd3);
    chk({name, "_idx"}, 64'(best_idx), 64'(ei));
    chk({name, "_dist"}, 64'(best_dist), 64'(ed));
    chk({name, "_center"}, 64'(best_center), 64'(ec));
    idle();
    repeat (3) @(negedge clk);
    chk({name, "_hold"}, 64'({best_idx, best_dist}), 64'({3'(ei), 10'(ed)}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] tie [8];
    int cnt;
    tie[0] = pk(105, 100, 100); tie[1] = pk(95, 100, 100);
    tie[2] = pk(100, 105, 100); tie[3] = pk(100, 95, 100);
    tie[4] = pk(100, 100, 105); tie[5] = pk(100, 100, 95);
    tie[6] = pk(102, 103, 100); tie[7] = pk(98, 100, 97);

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {cand_ready, busy, done, best_idx, best_dist, best_center}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_start(pk(10, 20, 30));
    send(pk(0, 0, 0), 0, 0);
    send(pk(12, 18, 33), 0, 0);
    send(pk(200, 200, 200), 1, 0);
    idle();
    wait_done("basic", 1, 7, pk(12, 18, 33));

    do_start(pk(0, 255, 0));
    send(pk(255, 0, 255), 1, 0);
    wait_done("full_range", 0, 765, pk(255, 0, 255));

    do_start(pk(200, 0, 0));
    send(pk(10, 0, 0), 1, 0);
    wait_done("abs_sign", 0, 190, pk(10, 0, 0));

    do_start(pk(100, 100, 100));
    for (int i = 0; i < 8; i++) send(tie[i], 0, 0);
    cand_valid = 1'b1; cand_center = pk(100, 100, 100); cand_last = 1'b1;
    chk("limit_ready", 64'(cand_ready), 64'd0);
    wait_done("tie_limit", 0, 5, pk(105, 100, 100));

    do_start(pk(10, 20, 30));
    send(pk(0, 0, 0), 0, 2);
    send(pk(12, 18, 33), 0, 2);
    send(pk(200, 200, 200), 1, 2);
    idle();
    wait_done("stall", 1, 7, pk(12, 18, 33));

    do_start(pk(10, 20, 30));
    send(pk(0, 0, 0), 0, 0);
    send(pk(12, 18, 33), 0, 0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    chk("abort_idle", 64'({busy, best_dist}), 64'd0);
    do_start(pk(5, 5, 5));
    send(pk(5, 5, 5), 1, 0);
    idle();
    wait_done("reset_new", 0, 0, pk(5, 5, 5));

    do_start(pk(50, 50, 50));
    send(pk(60, 50, 50), 0, 0);
    idle();
    start = 1'b1; point = pk(0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    send(pk(50, 50, 52), 1, 0);
    idle();
    wait_done("start_ign", 1, 2, pk(50, 50, 52));

    do_start(pk(7, 8, 9));
    send(pk(7, 8, 9), 0, 0);
    send(pk(7, 8, 9), 0, 0);
    send(pk(7, 8, 10), 1, 0);
    idle();
    wait_done("zero_dist", 0, 0, pk(7, 8, 9));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
